// File: rtl/sfp_norm_pkg.sv
// Shared definitions for the psum normalizer: FSM encoding and derived widths.
package sfp_norm_pkg;

    localparam int unsigned FRAC        = 8;
    localparam int unsigned DEF_BW_PSUM = 20;
    localparam int unsigned SUM_W       = DEF_BW_PSUM + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Sum width for a given psum lane width: lane abs needs one extra bit, eight lanes need two more.
    function automatic int unsigned sum_w(input int unsigned bw);
        return bw + 3;
    endfunction

endpackage

// File: rtl/sfp_norm_div.sv
// Restoring divider, one quotient bit per cycle; the caller owns the bit count and flags the final step.
module seq_div
    import sfp_norm_pkg::*;
#(
    parameter int unsigned DW = 28,
    parameter int unsigned VW = 23,
    parameter int unsigned QW = FRAC + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          last,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    logic [VW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [VW-1:0] src_rem;
    logic [DW-1:0] src_quo;
    logic [VW:0]   shifted;
    logic          ge;
    logic          step;

    // start performs the first iteration on the loaded operands so each division takes exactly DW cycles
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        step    = start | busy_q;
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        shifted = {src_rem, src_quo[DW-1]};
        ge      = (divisor != '0) && (shifted >= {1'b0, divisor});
        if (step) begin
            rem_d  = ge ? VW'(shifted - {1'b0, divisor}) : VW'(shifted);
            quo_d  = {src_quo[DW-2:0], ge};
            busy_d = ~last;
            done_d = last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q[QW-1:0];

endmodule

// File: rtl/sfp_norm.sv
// Psum row normalizer: each lane becomes floor(|lane|*256 / sum|lane|), lanes divided serially.
module sfp_norm
    import sfp_norm_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned bw_psum = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [col*bw_psum-1:0]      in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [col*bw_psum-1:0]      out,
    output logic [sum_w(bw_psum)-1:0]   sum_out,
    output logic                        out_valid
);

    localparam int unsigned ACC_W = sum_w(bw_psum);
    localparam int unsigned DW    = bw_psum + FRAC;
    localparam int unsigned QW    = FRAC + 1;
    localparam int unsigned LW    = (col > 1) ? $clog2(col) : 1;
    localparam int unsigned CW    = $clog2(DW);

    state_e                          state_q, state_d;
    logic [col-1:0][bw_psum-1:0]     lane_q, lane_d, lanes_res;
    logic [col-1:0][bw_psum-1:0]     out_q, out_d;
    logic [ACC_W-1:0]                sum_q, sum_d, sum_c;
    logic [ACC_W-1:0]                sum_out_q, sum_out_d;
    logic [LW-1:0]                   lane_cnt_q, lane_cnt_d;
    logic [LW-1:0]                   done_lane_q, done_lane_d;
    logic [CW-1:0]                   bit_cnt_q, bit_cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic                            in_ready_q, in_ready_d;

    logic                            div_start_c, div_last_c, div_done;
    logic [DW-1:0]                   div_dividend_c;
    logic [QW-1:0]                   div_quot;
    logic [bw_psum:0]                abs_sel;

    function automatic logic [bw_psum:0] abs_lane(input logic [bw_psum-1:0] v);
        logic [bw_psum:0] ext;
        ext = {v[bw_psum-1], v};
        return ext[bw_psum] ? (~ext + 1'b1) : ext;
    endfunction

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        lane_cnt_d  = lane_cnt_q;
        done_lane_d = done_lane_q;
        bit_cnt_d   = bit_cnt_q;
        out_d       = out_q;
        sum_out_d   = sum_out_q;
        out_valid_d = 1'b0;
        div_start_c = 1'b0;
        div_last_c  = 1'b0;

        sum_c = '0;
        for (int i = 0; i < int'(col); i++) begin
            sum_c = sum_c + ACC_W'(abs_lane(lane_q[i]));
        end
        abs_sel        = abs_lane(lane_q[lane_cnt_q]);
        div_dividend_c = DW'({abs_sel, FRAC'(0)});

        // A finished quotient replaces its own lane, which is no longer needed as a dividend
        lanes_res = lane_q;
        if (div_done) begin
            lanes_res[done_lane_q] = bw_psum'(div_quot);
        end
        lane_d = lanes_res;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    lane_d  = in;
                    state_d = SUM;
                end
            end
            SUM: begin
                sum_d      = sum_c;
                lane_cnt_d = '0;
                bit_cnt_d  = '0;
                state_d    = DIV;
            end
            DIV: begin
                div_start_c = (bit_cnt_q == '0);
                if (bit_cnt_q == CW'(DW - 1)) begin
                    div_last_c  = 1'b1;
                    bit_cnt_d   = '0;
                    done_lane_d = lane_cnt_q;
                    if (lane_cnt_q == LW'(col - 1)) begin
                        state_d = DONE;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_d       = lanes_res;
                sum_out_d   = sum_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            sum_q       <= '0;
            lane_cnt_q  <= '0;
            done_lane_q <= '0;
            bit_cnt_q   <= '0;
            out_q       <= '0;
            sum_out_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            sum_q       <= sum_d;
            lane_cnt_q  <= lane_cnt_d;
            done_lane_q <= done_lane_d;
            bit_cnt_q   <= bit_cnt_d;
            out_q       <= out_d;
            sum_out_q   <= sum_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    seq_div #(
        .DW (DW),
        .VW (ACC_W),
        .QW (QW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start_c),
        .last     (div_last_c),
        .dividend (div_dividend_c),
        .divisor  (sum_q),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign in_ready  = in_ready_q;
    assign out       = out_q;
    assign sum_out   = sum_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sfp_norm.sv
// Directed bench for sfp_norm with hand-computed expected lanes, sums and latency.
module tb_sfp_norm;

    localparam int unsigned COL = 8;
    localparam int unsigned BW  = 20;
    localparam int unsigned SW  = BW + 3;
    localparam int          LAT = 226;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic [COL*BW-1:0]   in_row;
    logic                in_ready;
    logic [COL*BW-1:0]   out_row;
    logic [SW-1:0]       sum_out;
    logic                out_valid;

    int                  n_tests = 0;
    int                  n_fail  = 0;
    int                  vin  [COL];
    int                  vexp [COL];
    logic [SW-1:0]       mid_sum;

    always #5 clk = ~clk;

    sfp_norm #(.col(COL), .bw_psum(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_row),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out_row),
        .sum_out   (sum_out),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COL*BW-1:0] pack_row();
        logic [COL*BW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(COL); i++) r[i*BW +: BW] = BW'(vin[i]);
        return r;
    endfunction

    // Waits for out_valid after an accept edge; n = cycles from accept, 0 on timeout
    task automatic wait_valid(output int n);
        n = 0;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (c == 5) check("busy_in_ready", 64'(in_ready), 64'd0);
            if (c == 100) mid_sum = sum_out;
            if (out_valid) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic check_lanes(input string name);
        for (int i = 0; i < int'(COL); i++)
            check($sformatf("%s_lane%0d", name, i), 64'(out_row[i*BW +: BW]), 64'(vexp[i]));
    endtask

    task automatic run_row(input string name, input logic [63:0] exp_sum);
        int n;
        in_row   = pack_row();
        in_valid = 1'b1;
        check({name, "_ready_pre"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        check({name, "_latency"}, 64'(n), 64'(LAT));
        check({name, "_sum"}, 64'(sum_out), exp_sum);
        check_lanes(name);
        check({name, "_ready_after"}, 64'(in_ready), 64'd1);
        tick();
        check({name, "_pulse_end"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int n;
        int pulses;

        // Reset with a row presented: nothing may be accepted
        reset    = 1'b1;
        in_valid = 1'b1;
        vin      = '{default: 100};
        in_row   = pack_row();
        repeat (3) tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out", 64'(|out_row), 64'd0);
        check("rst_sum", 64'(sum_out), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        tick();
        check("rst_not_accepted", 64'(in_ready), 64'd1);

        vin  = '{default: 100};
        vexp = '{default: 32};
        run_row("pos100", 64'd800);

        vin  = '{-256, 0, 0, 0, 0, 0, 0, 0};
        vexp = '{256, 0, 0, 0, 0, 0, 0, 0};
        run_row("neg256", 64'd256);

        vin  = '{default: -524288};
        vexp = '{default: 32};
        run_row("minneg", 64'd4194304);

        vin  = '{default: 0};
        vexp = '{default: 0};
        run_row("zero", 64'd0);

        vin  = '{1, 2, 3, 4, 5, 6, 7, -8};
        vexp = '{7, 14, 21, 28, 35, 42, 49, 56};
        run_row("mixed", 64'd36);

        vin  = '{524287, 1, -1, 1, -1, 1, -1, 1};
        vexp = '{255, 0, 0, 0, 0, 0, 0, 0};
        run_row("maxpos", 64'd524294);

        // Row A held, then B held while busy: B dropped until IDLE, then accepted
        vin      = '{default: 100};
        in_row   = pack_row();
        in_valid = 1'b1;
        tick();
        vin    = '{-256, 0, 0, 0, 0, 0, 0, 0};
        in_row = pack_row();
        wait_valid(n);
        check("hold_a_latency", 64'(n), 64'(LAT));
        check("hold_a_sum", 64'(sum_out), 64'd800);
        vexp = '{default: 32};
        check_lanes("hold_a");
        check("hold_ready_after_done", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        check("hold_b_latency", 64'(n), 64'(LAT));
        check("hold_b_mid_sum_held", 64'(mid_sum), 64'd800);
        check("hold_b_sum", 64'(sum_out), 64'd256);
        vexp = '{256, 0, 0, 0, 0, 0, 0, 0};
        check_lanes("hold_b");
        tick();

        // Reset 50 cycles into DIV
        vin      = '{default: 100};
        in_row   = pack_row();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (51) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("middiv_idle", 64'(in_ready), 64'd1);
        check("middiv_out", 64'(|out_row), 64'd0);
        check("middiv_sum", 64'(sum_out), 64'd0);
        check("middiv_valid", 64'(out_valid), 64'd0);
        pulses = 0;
        repeat (300) begin
            tick();
            if (out_valid) pulses++;
        end
        check("middiv_no_pulse", 64'(pulses), 64'd0);

        vin  = '{1, 2, 3, 4, 5, 6, 7, -8};
        vexp = '{7, 14, 21, 28, 35, 42, 49, 56};
        run_row("post_reset", 64'd36);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sfp_norm.md
SFP_NORM -- requirements
Module: sfp_norm

Interface
REQ-001 Parameter col, default 8, sets the number of psum lanes per row.
REQ-002 Parameter bw_psum, default 20, sets the signed width of one psum lane.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in, input, col*bw_psum bits: one psum row from PSUM memory read data; lane i is in[bw_psum*(i+1)-1 : bw_psum*i], two's complement.
REQ-006 Port in_valid, input, 1 bit: `in` holds a valid row this cycle.
REQ-007 Port in_ready, output, 1 bit: the block accepts a row this cycle.
REQ-008 Port out, output, col*bw_psum bits: normalized lanes, unsigned and zero-extended, same lane packing as `in`.
REQ-009 Port sum_out, output, bw_psum+3 bits: the sum of absolute values of the last accepted row.
REQ-010 Port out_valid, output, 1 bit: one-cycle pulse marking a new `out`/`sum_out` result.

Function
REQ-011 A row is accepted on a rising edge where in_valid=1 and in_ready=1; `in` is captured into lane registers on that edge.
REQ-012 in_ready SHALL be 1 only in IDLE; in_valid in any other state is ignored and the data is dropped.
REQ-013 The FSM SHALL have states IDLE, SUM, DIV and DONE.
REQ-014 Transitions: IDLE -> SUM on accept; SUM -> DIV after 1 cycle; DIV -> DONE after col*(bw_psum+8) cycles; DONE -> IDLE after 1 cycle.
REQ-015 SUM: compute abs(lane) for each lane as bw_psum+1 bits unsigned, so abs(-2^(bw_psum-1)) = 2^(bw_psum-1) exactly.
REQ-016 SUM: add all abs values without truncation into a bw_psum+3 bit sum register.
REQ-017 DIV: one shared restoring divider processes lanes in order 0..col-1, taking bw_psum+8 cycles per lane.
REQ-018 DIV: for each lane, the dividend is abs(lane_i)<<8 and the divisor is sum.
REQ-019 DIV: the lane result is floor(abs(lane_i)*256/sum), with range 0..256.
REQ-020 If sum==0, every lane result SHALL be 0 and the state timing SHALL be unchanged; there is no divide-by-zero path.
REQ-021 In DONE, `out` and `sum_out` update together and out_valid=1 for exactly that cycle.
REQ-022 Latency from the accept edge to out_valid is fixed at 2 + col*(bw_psum+8) cycles: 226 for the defaults.
REQ-023 `out` and `sum_out` SHALL hold their values until the next DONE; in_valid activity never disturbs them.
REQ-024 The earliest next accept is the cycle after DONE, so the maximum rate is one row per 3 + col*(bw_psum+8) cycles.

Reset
REQ-025 reset=1 at a rising edge SHALL force the FSM to IDLE from any state, including mid-DIV; the partial result is discarded.
REQ-026 On reset, `out`, `sum_out`, the lane registers, the divider state and out_valid SHALL all be 0.
REQ-027 On reset, in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-028 A row presented during a reset cycle is not accepted.

Structure
REQ-029 A shared package holds the FSM state encoding and the derived widths SUM_W = bw_psum+3 and FRAC = 8.
REQ-030 The divider is a sub-module seq_div (start, dividend, divisor, done, quotient), reused serially across lanes.
REQ-031 The lane-index counter and the per-lane bit counter live in sfp_norm.
REQ-032 No memories or multipliers are used; abs and the adder are combinational between registers.

Verification
REQ-033 All lanes +100 -> sum_out=800, every out lane=32, out_valid 226 cycles after accept.
REQ-034 Lane0=-256, other lanes 0 -> sum_out=256, out lane0=256, other lanes 0.
REQ-035 All lanes -524288 -> sum_out=4194304, every out lane=32, no overflow.
REQ-036 All lanes 0 -> sum_out=0, all out lanes 0, out_valid still at cycle 226.
REQ-037 in_valid held high with rows A then B -> A accepted, B dropped while busy, in_ready high again the cycle after DONE, the next held row accepted there.
REQ-038 reset asserted 50 cycles into DIV -> next cycle state IDLE, out=0, sum_out=0, no out_valid pulse.
